// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter
// Round-robin arbiter that shares one Wishbone bridge port between
// NUM_MASTERS Wishbone requesters. A granted request's fields are latched into
// registered bridge-side outputs and held until the bridge returns ack or err.
// The arbiter then spends one cycle in IDLE so the bridge's per-transfer done
// flags clear before the next request is issued.
//
// Ports:
//   clk                      clock, rising edge
//   rst                      asynchronous active-low reset
//   m_cyc_i/m_stb_i/m_we_i   per-master cycle, strobe and write enable
//   m_adr_i/m_dat_i/m_sel_i  per-master address/data/byte selects, master i in slice i
//   m_ack_o/m_err_o          per-master completion, only the live owner sees it
//   m_dat_o                  read data broadcast to all masters
//   s_cyc_o/s_stb_o/s_we_o   bridge-side cycle, strobe, write enable
//   s_adr_o/s_dat_o/s_sel_o  bridge-side latched address, write data, byte selects
//   s_ack_i/s_err_i/s_dat_i  bridge completion and read data
//   grant_o                  one-hot current owner, 0 in IDLE
//   busy_o                   high while a transfer is outstanding
module wb_mem_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_MASTERS-1:0]             m_cyc_i,
    input  logic [NUM_MASTERS-1:0]             m_stb_i,
    input  logic [NUM_MASTERS-1:0]             m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]  m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]  m_dat_i,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_sel_i,
    output logic [NUM_MASTERS-1:0]             m_ack_o,
    output logic [NUM_MASTERS-1:0]             m_err_o,
    output logic [DATA_WIDTH-1:0]              m_dat_o,
    output logic                               s_cyc_o,
    output logic                               s_stb_o,
    output logic                               s_we_o,
    output logic [ADDR_WIDTH-1:0]              s_adr_o,
    output logic [DATA_WIDTH-1:0]              s_dat_o,
    output logic [DATA_WIDTH/8-1:0]            s_sel_o,
    input  logic                               s_ack_i,
    input  logic                               s_err_i,
    input  logic [DATA_WIDTH-1:0]              s_dat_i,
    output logic [NUM_MASTERS-1:0]             grant_o,
    output logic                               busy_o
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state_reg, state_next;
    logic [NUM_MASTERS-1:0] grant_reg, grant_next;
    logic [IDX_W-1:0]       last_reg, last_next;
    logic                   abort_reg, abort_next;
    logic                   s_we_reg, s_we_next;
    logic [ADDR_WIDTH-1:0]  s_adr_reg, s_adr_next;
    logic [DATA_WIDTH-1:0]  s_dat_reg, s_dat_next;
    logic [SEL_WIDTH-1:0]   s_sel_reg, s_sel_next;

    logic [NUM_MASTERS-1:0] req;
    logic [ADDR_WIDTH-1:0]  adr_arr [NUM_MASTERS];
    logic [DATA_WIDTH-1:0]  dat_arr [NUM_MASTERS];
    logic [SEL_WIDTH-1:0]   sel_arr [NUM_MASTERS];

    // Unpack the flat per-master buses so the winner can be picked by index.
    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
            assign req[gi]     = m_cyc_i[gi] & m_stb_i[gi];
            assign adr_arr[gi] = m_adr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign dat_arr[gi] = m_dat_i[gi*DATA_WIDTH +: DATA_WIDTH];
            assign sel_arr[gi] = m_sel_i[gi*SEL_WIDTH +: SEL_WIDTH];
        end
    endgenerate

    // Round-robin search starting just after the last winner.
    logic             found;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] cand;
    int               idx;

    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        cand    = '0;
        idx     = 0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx = int'(last_reg) + k;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            cand = IDX_W'(idx);
            if (!found && req[cand]) begin
                found   = 1'b1;
                sel_idx = cand;
            end
        end
    end

    // Owner still in its cycle; once it has let go, the outstanding bridge
    // completion must be swallowed even if the master re-raises cyc later.
    logic owner_cyc;
    logic fwd;

    assign owner_cyc = |(grant_reg & m_cyc_i);
    assign fwd       = (state_reg == BUSY) && owner_cyc && !abort_reg;

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        last_next  = last_reg;
        abort_next = abort_reg;
        s_we_next  = s_we_reg;
        s_adr_next = s_adr_reg;
        s_dat_next = s_dat_reg;
        s_sel_next = s_sel_reg;
        case (state_reg)
            IDLE: begin
                if (found) begin
                    state_next          = BUSY;
                    grant_next          = '0;
                    grant_next[sel_idx] = 1'b1;
                    last_next           = sel_idx;
                    abort_next          = 1'b0;
                    s_we_next           = m_we_i[sel_idx];
                    s_adr_next          = adr_arr[sel_idx];
                    s_dat_next          = dat_arr[sel_idx];
                    s_sel_next          = sel_arr[sel_idx];
                end
            end
            BUSY: begin
                if (!owner_cyc) abort_next = 1'b1;
                if (s_ack_i || s_err_i) begin
                    state_next = IDLE;
                    grant_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            last_reg  <= IDX_W'(NUM_MASTERS - 1);
            abort_reg <= 1'b0;
            s_we_reg  <= 1'b0;
            s_adr_reg <= '0;
            s_dat_reg <= '0;
            s_sel_reg <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            last_reg  <= last_next;
            abort_reg <= abort_next;
            s_we_reg  <= s_we_next;
            s_adr_reg <= s_adr_next;
            s_dat_reg <= s_dat_next;
            s_sel_reg <= s_sel_next;
        end
    end

    assign busy_o  = (state_reg == BUSY);
    assign s_cyc_o = busy_o;
    assign s_stb_o = busy_o;
    assign s_we_o  = s_we_reg;
    assign s_adr_o = s_adr_reg;
    assign s_dat_o = s_dat_reg;
    assign s_sel_o = s_sel_reg;
    assign grant_o = grant_reg;
    assign m_dat_o = s_dat_i;
    assign m_ack_o = (fwd && s_ack_i) ? grant_reg : '0;
    assign m_err_o = (fwd && s_err_i) ? grant_reg : '0;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter with two 64-bit masters. Inputs change
// 1 ns after the rising edge; outputs are checked 3 ns after the edge.
module tb_wb_mem_arbiter;

    logic         clk;
    logic         rst;
    logic [1:0]   m_cyc_i, m_stb_i, m_we_i;
    logic [63:0]  m_adr_i;
    logic [127:0] m_dat_i;
    logic [15:0]  m_sel_i;
    logic [1:0]   m_ack_o, m_err_o;
    logic [63:0]  m_dat_o;
    logic         s_cyc_o, s_stb_o, s_we_o;
    logic [31:0]  s_adr_o;
    logic [63:0]  s_dat_o;
    logic [7:0]   s_sel_o;
    logic         s_ack_i, s_err_i;
    logic [63:0]  s_dat_i;
    logic [1:0]   grant_o;
    logic         busy_o;

    int errors = 0;
    int checks = 0;

    wb_mem_arbiter #(.NUM_MASTERS(2), .DATA_WIDTH(64), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_dat_i(s_dat_i),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] order [4];

    initial begin
        order = '{2'b01, 2'b10, 2'b01, 2'b10};
        rst = 1'b0;
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
        m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
        s_ack_i = 1'b0; s_err_i = 1'b0; s_dat_i = '0;

        // Reset state
        nxt(); nxt(); #2;
        chk("rst_busy", busy_o, 0);
        chk("rst_grant", grant_o, 0);
        chk("rst_stb", s_stb_o, 0);
        chk("rst_adr", s_adr_o, 0);
        nxt(); rst = 1'b1;

        // Single write from master 1
        nxt();
        m_cyc_i = 2'b10; m_stb_i = 2'b10; m_we_i = 2'b10;
        m_adr_i[63:32] = 32'h8000_0040;
        m_dat_i[127:64] = 64'hDEAD_BEEF_0123_4567;
        m_sel_i[15:8] = 8'hFF;
        #2;
        chk("t1_idle_busy", busy_o, 0);
        chk("t1_idle_grant", grant_o, 0);
        nxt(); #2;
        chk("t1_stb", s_stb_o, 1);
        chk("t1_cyc", s_cyc_o, 1);
        chk("t1_grant", grant_o, 2'b10);
        chk("t1_adr", s_adr_o, 64'h8000_0040);
        chk("t1_dat", s_dat_o, 64'hDEAD_BEEF_0123_4567);
        chk("t1_sel", s_sel_o, 8'hFF);
        chk("t1_we", s_we_o, 1);
        chk("t1_noack", m_ack_o, 0);
        nxt(); #2;
        chk("t1_wait_ack", m_ack_o, 0);
        nxt(); nxt();
        s_ack_i = 1'b1; s_dat_i = 64'h1122_3344_5566_7788;
        #2;
        chk("t1_ack", m_ack_o, 2'b10);
        chk("t1_mdat", m_dat_o, 64'h1122_3344_5566_7788);
        nxt();
        s_ack_i = 1'b0; m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
        #2;
        chk("t1_done_busy", busy_o, 0);
        chk("t1_done_stb", s_stb_o, 0);

        // Contention: both request continuously
        nxt();
        m_cyc_i = 2'b11; m_stb_i = 2'b11;
        #2;
        for (int t = 0; t < 4; t++) begin
            nxt();
            s_ack_i = 1'b1;
            #2;
            $display("contention transfer %0d grant=%b", t, grant_o);
            chk("t2_grant", grant_o, order[t]);
            chk("t2_stb", s_stb_o, 1);
            chk("t2_ack", m_ack_o, order[t]);
            nxt();
            s_ack_i = 1'b0;
            if (t == 3) begin
                m_cyc_i = '0; m_stb_i = '0;
            end
            #2;
            chk("t2_gap_stb", s_stb_o, 0);
        end

        // Error path: master 0 read
        nxt();
        m_cyc_i = 2'b01; m_stb_i = 2'b01; m_we_i = 2'b00;
        m_adr_i[31:0] = 32'h0000_0040;
        #2;
        nxt();
        s_err_i = 1'b1;
        #2;
        chk("t3_grant", grant_o, 2'b01);
        chk("t3_we", s_we_o, 0);
        chk("t3_err", m_err_o, 2'b01);
        chk("t3_noack", m_ack_o, 0);
        nxt();
        s_err_i = 1'b0; m_cyc_i = '0; m_stb_i = '0;
        #2;
        chk("t3_idle", busy_o, 0);
        chk("t3_err_clr", m_err_o, 0);

        // Field stability
        nxt();
        m_cyc_i = 2'b01; m_stb_i = 2'b01;
        m_adr_i[31:0] = 32'h0000_0100;
        #2;
        nxt();
        m_adr_i[31:0] = 32'h0000_0200;
        #2;
        chk("t4_adr_a", s_adr_o, 32'h100);
        nxt(); #2;
        chk("t4_adr_b", s_adr_o, 32'h100);
        nxt();
        s_ack_i = 1'b1;
        #2;
        chk("t4_adr_c", s_adr_o, 32'h100);
        chk("t4_ack", m_ack_o, 2'b01);
        nxt();
        s_ack_i = 1'b0; m_cyc_i = '0; m_stb_i = '0;
        #2;

        // Abort by master 0 with master 1 pending
        nxt();
        m_cyc_i = 2'b01; m_stb_i = 2'b01;
        #2;
        nxt();
        m_cyc_i = 2'b11; m_stb_i = 2'b11;
        m_adr_i[63:32] = 32'h0000_0300;
        #2;
        chk("t5_grant0", grant_o, 2'b01);
        nxt();
        m_cyc_i = 2'b10; m_stb_i = 2'b10;
        #2;
        chk("t5_cyc_held", s_cyc_o, 1);
        nxt();
        s_ack_i = 1'b1;
        #2;
        chk("t5_absorbed", m_ack_o, 0);
        chk("t5_cyc_at_ack", s_cyc_o, 1);
        nxt();
        s_ack_i = 1'b0;
        #2;
        chk("t5_idle", busy_o, 0);
        nxt();
        s_ack_i = 1'b1;
        #2;
        chk("t5_grant1", grant_o, 2'b10);
        chk("t5_adr1", s_adr_o, 32'h300);
        chk("t5_ack1", m_ack_o, 2'b10);
        nxt();
        s_ack_i = 1'b0; m_cyc_i = '0; m_stb_i = '0;
        #2;

        // Reset mid-BUSY, master 0 owns (so last would otherwise be 0)
        nxt();
        m_cyc_i = 2'b01; m_stb_i = 2'b01;
        #2;
        nxt(); #2;
        chk("t6_stb_before", s_stb_o, 1);
        nxt();
        rst = 1'b0;
        #1;
        chk("t6_async_stb", s_stb_o, 0);
        chk("t6_async_busy", busy_o, 0);
        chk("t6_async_grant", grant_o, 0);
        chk("t6_async_adr", s_adr_o, 0);
        m_cyc_i = '0; m_stb_i = '0;
        nxt();
        rst = 1'b1;
        nxt();
        s_ack_i = 1'b1;
        #2;
        chk("t6_stray_ack", m_ack_o, 0);
        chk("t6_stray_busy", busy_o, 0);
        nxt();
        s_ack_i = 1'b0;
        m_cyc_i = 2'b11; m_stb_i = 2'b11;
        #2;
        nxt(); #2;
        chk("t6_prio_after_rst", grant_o, 2'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_mem_arbiter.md
# wb_mem_arbiter

Round-robin arbiter that shares the single Wishbone-to-AXI bridge port of the L1 memory subsystem between NUM_MASTERS Wishbone requesters, e.g. I-cache refill and D-cache refill/writeback. It grants one requester at a time and latches that request's fields into registered slave-side outputs. It holds the grant until the bridge returns ack or err, then releases the bus for at least one idle cycle so the bridge's per-transfer done flags clear before the next request.

## Interface
- NUM_MASTERS, 2: number of requesters, 2..8
- DATA_WIDTH, 64: Wishbone data width
- ADDR_WIDTH, 32: Wishbone address width

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- m_cyc_i  in  NUM_MASTERS  per-master cycle
- m_stb_i  in  NUM_MASTERS  per-master strobe
- m_we_i  in  NUM_MASTERS  per-master write enable
- m_adr_i  in  NUM_MASTERS*ADDR_WIDTH  master i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- m_dat_i  in  NUM_MASTERS*DATA_WIDTH  write data, sliced the same way
- m_sel_i  in  NUM_MASTERS*DATA_WIDTH/8  byte selects, sliced the same way
- m_ack_o  out  NUM_MASTERS  per-master ack
- m_err_o  out  NUM_MASTERS  per-master error
- m_dat_o  out  DATA_WIDTH  read data, broadcast to all masters (= s_dat_i)
- s_cyc_o, s_stb_o, s_we_o  out  1  bridge-side cycle, strobe, write enable
- s_adr_o  out  ADDR_WIDTH  bridge-side address
- s_dat_o  out  DATA_WIDTH  bridge-side write data
- s_sel_o  out  DATA_WIDTH/8  bridge-side byte selects
- s_ack_i, s_err_i  in  1  bridge completion
- s_dat_i  in  DATA_WIDTH  bridge read data
- grant_o  out  NUM_MASTERS  one-hot current owner; 0 when IDLE
- busy_o  out  1  high in BUSY

## Operation
- req[i] = m_cyc_i[i] & m_stb_i[i].
- States: IDLE and BUSY.
- IDLE: if any req is set, select the first requesting master searching last_q+1, last_q+2, … with wrap modulo NUM_MASTERS.
  - On the edge: grant_q ← one-hot(sel), last_q ← sel, latch we/adr/dat/sel of sel into s_* registers, go BUSY.
  - If no req is set, stay in IDLE.
- BUSY:
  - s_cyc_o = s_stb_o = 1.
  - s_we_o, s_adr_o, s_dat_o and s_sel_o hold their latched values; master inputs are not re-sampled.
  - On s_ack_i | s_err_i: m_ack_o[g] = s_ack_i and m_err_o[g] = s_err_i, both combinational and only while m_cyc_i[g] = 1. At the edge: go IDLE, grant_q ← 0.
  - If s_ack_i and s_err_i are both high, both are forwarded.
- Abort: if the owner drops m_cyc_i while in BUSY, the arbiter keeps the slave cycle asserted with the latched fields until ack/err arrives. That completion is absorbed and not forwarded. The bridge cannot cancel an AXI transfer.
- In IDLE, s_ack_i and s_err_i are ignored and all m_ack_o/m_err_o are 0.
- Non-owners never see ack or err.
- Reset: state = IDLE, grant_q = 0, last_q = NUM_MASTERS-1 (master 0 has first priority), all s_* outputs = 0, busy_o = 0. Reset asserted mid-transfer returns to IDLE immediately; any later bridge completion is ignored as spurious.

## Timing
- Request first seen in IDLE during cycle n: s_stb_o and grant_o are high from cycle n+1.
- Completion in cycle k: m_ack_o/m_err_o are high in cycle k (zero added latency); IDLE in cycle k+1; earliest next s_stb_o in cycle k+2.
- This gives a guaranteed ≥1-cycle s_stb_o low gap between transfers.
- Fairness: with all masters requesting continuously, each master is granted exactly once per NUM_MASTERS grants.
- Worst-case wait: (NUM_MASTERS-1) transfers plus one idle cycle each.

## Test plan
- Single request: master 1 writes adr 0x8000_0040, dat 0xDEAD_BEEF_0123_4567, sel 0xFF. Expect s_stb_o in the cycle after the request with identical fields. Bridge acks 3 cycles later; m_ack_o[1] pulses in the same cycle; m_ack_o[0] stays 0.
- Contention: both masters request simultaneously after reset. Expect grant order 0, 1, 0, 1 over 4 transfers, with s_stb_o low for exactly 1 cycle between them.
- Error path: master 0 reads and the bridge returns s_err_i. Expect m_err_o[0] = 1, m_ack_o[0] = 0, and the state returns to IDLE.
- Field stability: the owner changes m_adr_i from 0x100 to 0x200 during BUSY. Expect s_adr_o to remain 0x100 until ack.
- Abort: master 0 drops m_cyc_i 1 cycle after grant. Expect s_cyc_o held until s_ack_i, with no m_ack_o pulse; master 1's pending request is granted 2 cycles after that ack.
- Reset mid-BUSY: assert rst low while s_stb_o = 1. Expect all outputs 0 asynchronously. After release, a subsequent stray s_ack_i produces no m_ack_o.
